mux4_rr_sel_ctrl: RTL

//  Round-robin select controller that drives the 4:1 mux stage directly downstream.

---
 rtl/mux4_rr_sel_ctrl_pkg.sv | 17 +
 rtl/mux4_rr_sel_ctrl_if.sv | 24 ++
 rtl/mux4_rr_sel_ctrl_rr_pick4.sv | 27 ++
 rtl/mux4_rr_sel_ctrl.sv | 99 +++++++++
 4 files changed

// File: rtl/mux4_rr_sel_ctrl_pkg.sv
// Shared constants and types for the round-robin 4:1 select controller.
package mux4_rr_sel_ctrl_pkg;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  function automatic logic [N_CH-1:0] sel2onehot(input logic [SEL_W-1:0] sel);
    logic [N_CH-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction
endpackage

// File: rtl/mux4_rr_sel_ctrl_if.sv
// Request/data/handshake bundle between four requesters, the controller and its consumer.
interface mux4_rr_sel_ctrl_if
  import mux4_rr_sel_ctrl_pkg::*;
#(
  parameter int WIDTH = 1
);
  logic [N_CH-1:0]       req;
  logic [N_CH*WIDTH-1:0] din;
  logic [SEL_W-1:0]      s;
  logic [WIDTH-1:0]      y;
  logic                  out_valid;
  logic                  out_ready;
  logic [N_CH-1:0]       gnt;

  modport master (
    output req, din, out_ready,
    input  s, y, out_valid, gnt
  );

  modport slave (
    input  req, din, out_ready,
    output s, y, out_valid, gnt
  );
endinterface

// File: rtl/mux4_rr_sel_ctrl_rr_pick4.sv
// Combinational round-robin picker: rotate by ptr, priority-encode, rotate back.
module rr_pick4
  import mux4_rr_sel_ctrl_pkg::*;
(
  input  logic [N_CH-1:0]  i_req,
  input  logic [SEL_W-1:0] i_ptr,
  input  logic             i_excl_en,
  input  logic [SEL_W-1:0] i_excl,
  output logic             o_any,
  output logic [SEL_W-1:0] o_idx
);
  logic [N_CH-1:0]  w_req_m;
  logic [N_CH-1:0]  w_rot;
  logic [SEL_W-1:0] w_off;

  always_comb begin
    w_req_m = i_req;
    if (i_excl_en) w_req_m[i_excl] = 1'b0;
    // w_rot[0] is the channel at ptr, so the lowest set bit is the winner
    for (int i = 0; i < N_CH; i++) w_rot[i] = w_req_m[SEL_W'(i) + i_ptr];
    w_off = '0;
    for (int i = N_CH - 1; i >= 0; i--) if (w_rot[i]) w_off = SEL_W'(i);
  end

  assign o_any = |w_req_m;
  assign o_idx = w_off + i_ptr;
endmodule

// File: rtl/mux4_rr_sel_ctrl.sv
// Round-robin select controller: picks a requester, registers its select and data,
// holds them under valid/ready and pulses gnt on acceptance.
module mux4_rr_sel_ctrl
  import mux4_rr_sel_ctrl_pkg::*;
#(
  parameter int WIDTH = 1
)(
  input  logic               clk,
  input  logic               rst_n,
  mux4_rr_sel_ctrl_if.slave  bus
);
  state_t           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_s, w_s_nxt;
  logic [WIDTH-1:0] r_y, w_y_nxt;
  logic             r_valid, w_valid_nxt;
  logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
  logic [N_CH-1:0]  r_gnt, w_gnt_nxt;

  logic             w_in_hold;
  logic [SEL_W-1:0] w_pick_ptr;
  logic             w_any;
  logic [SEL_W-1:0] w_idx;
  logic [WIDTH-1:0] w_pick_data;

  assign w_in_hold = (r_state == ST_HOLD);
  // In HOLD the picker is only consulted on accept, where the search starts after s
  assign w_pick_ptr = w_in_hold ? (r_s + SEL_W'(1)) : r_ptr;

  rr_pick4 u_pick (
    .i_req     (bus.req),
    .i_ptr     (w_pick_ptr),
    .i_excl_en (w_in_hold),
    .i_excl    (r_s),
    .o_any     (w_any),
    .o_idx     (w_idx)
  );

  always_comb begin
    w_pick_data = '0;
    for (int k = 0; k < N_CH; k++)
      if (w_idx == SEL_W'(k)) w_pick_data = bus.din[k*WIDTH +: WIDTH];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_y_nxt     = r_y;
    w_valid_nxt = r_valid;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_s_nxt     = w_idx;
          w_y_nxt     = w_pick_data;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          w_gnt_nxt = sel2onehot(r_s);
          w_ptr_nxt = r_s + SEL_W'(1);
          if (w_any) begin
            w_s_nxt = w_idx;
            w_y_nxt = w_pick_data;
          end else begin
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_y     <= w_y_nxt;
      r_valid <= w_valid_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  assign bus.s         = r_s;
  assign bus.y         = r_y;
  assign bus.out_valid = r_valid;
  assign bus.gnt       = r_gnt;
endmodule
